mem_port_arbiter: RTL

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates one memory controller between refresh, port A (CPU, read/write)
// and port B (video, read-only). Refresh goes first, then A/B round-robin.
module mem_port_arbiter #(
    parameter int REFRESH_INTERVAL = 600,
    parameter int TIMEOUT          = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        a_req,
    input  logic        a_we,
    input  logic [21:0] a_addr,
    input  logic [7:0]  a_din,
    output logic        a_ack,
    output logic [7:0]  a_dout,
    input  logic        b_req,
    input  logic [21:0] b_addr,
    output logic        b_ack,
    output logic [7:0]  b_dout,
    output logic        mc_read,
    output logic        mc_write,
    output logic        mc_refresh,
    output logic [21:0] mc_addr,
    output logic [7:0]  mc_din,
    input  logic [7:0]  mc_dout,
    input  logic        mc_busy,
    output logic        ready,
    output logic        timeout
);
    localparam int TW = (REFRESH_INTERVAL > 1) ? $clog2(REFRESH_INTERVAL) : 1;
    localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {INIT, IDLE, ISSUE, ACCEPT, DONE} state_t;
    typedef enum logic [1:0] {OWN_REF, OWN_A, OWN_B} owner_t;

    state_t        state_q, state_d;
    owner_t        owner_q, owner_d;
    logic          we_q, we_d;
    logic          ready_q, ready_d;
    logic          timeout_q, timeout_d;
    logic          a_ack_q, a_ack_d;
    logic          b_ack_q, b_ack_d;
    logic [7:0]    a_dout_q, a_dout_d;
    logic [7:0]    b_dout_q, b_dout_d;
    logic          mc_read_q, mc_read_d;
    logic          mc_write_q, mc_write_d;
    logic          mc_refresh_q, mc_refresh_d;
    logic [21:0]   mc_addr_q, mc_addr_d;
    logic [7:0]    mc_din_q, mc_din_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [1:0]    debt_q, debt_d;
    logic          prefer_b_q, prefer_b_d;
    logic [WW-1:0] wd_q, wd_d;

    logic wrap, ref_grant, wd_hit, finish, give_up;

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        we_d         = we_q;
        ready_d      = ready_q;
        timeout_d    = timeout_q;
        a_ack_d      = 1'b0;
        b_ack_d      = 1'b0;
        a_dout_d     = a_dout_q;
        b_dout_d     = b_dout_q;
        mc_read_d    = 1'b0;
        mc_write_d   = 1'b0;
        mc_refresh_d = 1'b0;
        mc_addr_d    = mc_addr_q;
        mc_din_d     = mc_din_q;
        prefer_b_d   = prefer_b_q;
        wd_d         = wd_q;
        debt_d       = debt_q;
        ref_grant    = 1'b0;
        finish       = 1'b0;
        give_up      = 1'b0;
        wrap         = (timer_q == TW'(REFRESH_INTERVAL - 1));
        timer_d      = wrap ? '0 : timer_q + 1'b1;
        wd_hit       = (wd_q == WW'(TIMEOUT - 1));

        case (state_q)
            INIT: begin
                if (!mc_busy) begin
                    state_d = IDLE;
                    ready_d = 1'b1;
                end
            end
            IDLE: begin
                // The cycle showing an ack is a dead cycle so a requester
                // still holding req from the finished access is not re-granted.
                if (!(a_ack_q || b_ack_q)) begin
                    if (debt_q != 2'd0) begin
                        ref_grant    = 1'b1;
                        owner_d      = OWN_REF;
                        we_d         = 1'b0;
                        mc_addr_d    = '0;
                        mc_din_d     = '0;
                        mc_refresh_d = 1'b1;
                        state_d      = ISSUE;
                    end else if (a_req && (!b_req || !prefer_b_q)) begin
                        owner_d    = OWN_A;
                        we_d       = a_we;
                        mc_addr_d  = a_addr;
                        mc_din_d   = a_din;
                        mc_write_d = a_we;
                        mc_read_d  = !a_we;
                        prefer_b_d = 1'b1;
                        state_d    = ISSUE;
                    end else if (b_req) begin
                        owner_d    = OWN_B;
                        we_d       = 1'b0;
                        mc_addr_d  = b_addr;
                        mc_din_d   = '0;
                        mc_read_d  = 1'b1;
                        prefer_b_d = 1'b0;
                        state_d    = ISSUE;
                    end
                end
            end
            ISSUE: begin
                wd_d    = '0;
                state_d = ACCEPT;
            end
            ACCEPT: begin
                if (wd_hit) begin
                    give_up = 1'b1;
                end else begin
                    wd_d = wd_q + 1'b1;
                    if (mc_busy) state_d = DONE;
                end
            end
            DONE: begin
                // A completion arriving on the last watchdog cycle still counts.
                if (!mc_busy) begin
                    finish = 1'b1;
                end else if (wd_hit) begin
                    give_up = 1'b1;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            default: state_d = INIT;
        endcase

        if (finish || give_up) begin
            state_d = IDLE;
            a_ack_d = (owner_q == OWN_A);
            b_ack_d = (owner_q == OWN_B);
        end
        if (finish && owner_q == OWN_A && !we_q) a_dout_d = mc_dout;
        if (finish && owner_q == OWN_B)          b_dout_d = mc_dout;
        if (give_up)                             timeout_d = 1'b1;

        if (wrap && !ref_grant && debt_q != 2'd3) debt_d = debt_q + 2'd1;
        else if (!wrap && ref_grant)              debt_d = debt_q - 2'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= INIT;
            owner_q      <= OWN_REF;
            we_q         <= 1'b0;
            ready_q      <= 1'b0;
            timeout_q    <= 1'b0;
            a_ack_q      <= 1'b0;
            b_ack_q      <= 1'b0;
            a_dout_q     <= '0;
            b_dout_q     <= '0;
            mc_read_q    <= 1'b0;
            mc_write_q   <= 1'b0;
            mc_refresh_q <= 1'b0;
            mc_addr_q    <= '0;
            mc_din_q     <= '0;
            timer_q      <= '0;
            debt_q       <= '0;
            prefer_b_q   <= 1'b1;
            wd_q         <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            we_q         <= we_d;
            ready_q      <= ready_d;
            timeout_q    <= timeout_d;
            a_ack_q      <= a_ack_d;
            b_ack_q      <= b_ack_d;
            a_dout_q     <= a_dout_d;
            b_dout_q     <= b_dout_d;
            mc_read_q    <= mc_read_d;
            mc_write_q   <= mc_write_d;
            mc_refresh_q <= mc_refresh_d;
            mc_addr_q    <= mc_addr_d;
            mc_din_q     <= mc_din_d;
            timer_q      <= timer_d;
            debt_q       <= debt_d;
            prefer_b_q   <= prefer_b_d;
            wd_q         <= wd_d;
        end
    end

    assign a_ack      = a_ack_q;
    assign b_ack      = b_ack_q;
    assign a_dout     = a_dout_q;
    assign b_dout     = b_dout_q;
    assign mc_read    = mc_read_q;
    assign mc_write   = mc_write_q;
    assign mc_refresh = mc_refresh_q;
    assign mc_addr    = mc_addr_q;
    assign mc_din     = mc_din_q;
    assign ready      = ready_q;
    assign timeout    = timeout_q;

endmodule
